// File: rtl/cond_exec_stage.sv
// EX pipeline register with condition-code qualification: annuls failing instructions,
// updates the status flags on retire and counts annulled instructions.
module cond_exec_stage #(
  parameter int COND_LEN = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [COND_LEN-1:0] id_cond,
  input  logic                id_s,
  input  logic                id_wb_en,
  input  logic                id_mem_r,
  input  logic                id_mem_w,
  input  logic                id_branch,
  input  logic [3:0]          id_dest,
  input  logic [31:0]         id_val1,
  input  logic [31:0]         id_val2,
  input  logic [3:0]          alu_flags,
  input  logic                cond_state,
  output logic [COND_LEN-1:0] ex_cond,
  output logic [3:0]          status_register,
  output logic                ex_valid,
  output logic                ex_wb_en,
  output logic                ex_mem_r,
  output logic                ex_mem_w,
  output logic                ex_branch,
  output logic [3:0]          ex_dest,
  output logic [31:0]         ex_val1,
  output logic [31:0]         ex_val2,
  output logic [CNT_W-1:0]    kill_count
);

  localparam logic [CNT_W-1:0] KILL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] KILL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                valid_r;
  logic [COND_LEN-1:0] cond_r;
  logic                s_r;
  logic                wb_en_r;
  logic                mem_r_r;
  logic                mem_w_r;
  logic                branch_r;
  logic [3:0]          dest_r;
  logic [31:0]         val1_r;
  logic [31:0]         val2_r;
  logic [3:0]          status_r;
  logic [CNT_W-1:0]    kill_r;
  logic                retire_s;

  // An instruction leaves EX on an unfrozen edge or when flushed out from under a freeze.
  assign retire_s = valid_r & (~freeze | flush);

  // EX register: flush clears, freeze holds, otherwise load from ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r  <= 1'b0;
      cond_r   <= {COND_LEN{1'b0}};
      s_r      <= 1'b0;
      wb_en_r  <= 1'b0;
      mem_r_r  <= 1'b0;
      mem_w_r  <= 1'b0;
      branch_r <= 1'b0;
      dest_r   <= 4'h0;
      val1_r   <= 32'h0000_0000;
      val2_r   <= 32'h0000_0000;
    end else if (flush) begin
      valid_r  <= 1'b0;
      cond_r   <= {COND_LEN{1'b0}};
      s_r      <= 1'b0;
      wb_en_r  <= 1'b0;
      mem_r_r  <= 1'b0;
      mem_w_r  <= 1'b0;
      branch_r <= 1'b0;
      dest_r   <= 4'h0;
      val1_r   <= 32'h0000_0000;
      val2_r   <= 32'h0000_0000;
    end else if (!freeze) begin
      valid_r  <= id_valid;
      cond_r   <= id_cond;
      s_r      <= id_s;
      wb_en_r  <= id_wb_en;
      mem_r_r  <= id_mem_r;
      mem_w_r  <= id_mem_w;
      branch_r <= id_branch;
      dest_r   <= id_dest;
      val1_r   <= id_val1;
      val2_r   <= id_val2;
    end else begin
      valid_r  <= valid_r;
      cond_r   <= cond_r;
      s_r      <= s_r;
      wb_en_r  <= wb_en_r;
      mem_r_r  <= mem_r_r;
      mem_w_r  <= mem_w_r;
      branch_r <= branch_r;
      dest_r   <= dest_r;
      val1_r   <= val1_r;
      val2_r   <= val2_r;
    end
  end

  // Flags commit only once, at retire, so a frozen instruction re-evaluates against the old flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_r <= 4'b0000;
    end else if (retire_s && s_r && cond_state) begin
      status_r <= alu_flags;
    end else begin
      status_r <= status_r;
    end
  end

  // Saturating count of instructions annulled by a failed condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_r <= {CNT_W{1'b0}};
    end else if (retire_s && !cond_state && (kill_r != KILL_MAX)) begin
      kill_r <= kill_r + KILL_ONE;
    end else begin
      kill_r <= kill_r;
    end
  end

  assign ex_cond         = cond_r;
  assign status_register = status_r;
  assign kill_count      = kill_r;
  assign ex_valid        = valid_r & cond_state;
  assign ex_wb_en        = valid_r & wb_en_r & cond_state;
  assign ex_mem_r        = valid_r & mem_r_r & cond_state;
  assign ex_mem_w        = valid_r & mem_w_r & cond_state;
  assign ex_branch       = valid_r & branch_r & cond_state;
  assign ex_dest         = dest_r;
  assign ex_val1         = val1_r;
  assign ex_val2         = val2_r;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Scoreboard bench for cond_exec_stage: a per-instruction reference model predicts
// EX outputs, flags and annul count; a monitor compares them each cycle.
module tb_cond_exec_stage;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cond;
    logic        s;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        br;
    logic [3:0]  dest;
    logic [31:0] v1;
    logic [31:0] v2;
  } instr_t;

  typedef struct packed {
    logic [4:0]       ctl;
    logic [3:0]       cond;
    logic [3:0]       dest;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [3:0]       status;
    logic [CNT_W-1:0] kill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0, flush = 1'b0, cond_state = 1'b0;
  logic [3:0] alu_flags = 4'h0;
  instr_t id = '0;

  logic [3:0] ex_cond, status_register, ex_dest;
  logic ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch;
  logic [31:0] ex_val1, ex_val2;
  logic [CNT_W-1:0] kill_count;

  int total = 0;
  int bad = 0;
  exp_t sb_q[$];

  // reference model state: the instruction sitting in EX, flags, annul count
  instr_t m_ex = '0;
  logic [3:0] m_status = 4'h0;
  int m_kill = 0;

  always #5 clk = ~clk;

  cond_exec_stage #(.COND_LEN(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id.valid), .id_cond(id.cond), .id_s(id.s), .id_wb_en(id.wb),
    .id_mem_r(id.mr), .id_mem_w(id.mw), .id_branch(id.br), .id_dest(id.dest),
    .id_val1(id.v1), .id_val2(id.v2), .alu_flags(alu_flags), .cond_state(cond_state),
    .ex_cond(ex_cond), .status_register(status_register), .ex_valid(ex_valid),
    .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_branch(ex_branch),
    .ex_dest(ex_dest), .ex_val1(ex_val1), .ex_val2(ex_val2), .kill_count(kill_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares whatever the DUT presents against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ctl", {59'd0, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch}, {59'd0, e.ctl});
        chk("cond", {60'd0, ex_cond}, {60'd0, e.cond});
        chk("dest", {60'd0, ex_dest}, {60'd0, e.dest});
        chk("val", {ex_val1, ex_val2}, {e.v1, e.v2});
        chk("status", {60'd0, status_register}, {60'd0, e.status});
        chk("kill", {{(64-CNT_W){1'b0}}, kill_count}, {{(64-CNT_W){1'b0}}, e.kill});
      end
    end
  end

  // one clock of stimulus: predict the outputs seen this cycle, then apply the edge to the model
  task automatic step(input instr_t i, input logic fz, input logic fl, input logic cs,
                      input logic [3:0] af);
    exp_t e;
    @(negedge clk);
    id = i; freeze = fz; flush = fl; cond_state = cs; alu_flags = af;
    #1;
    e.ctl    = m_ex.valid && cs ? {1'b1, m_ex.wb, m_ex.mr, m_ex.mw, m_ex.br} : 5'b00000;
    e.cond   = m_ex.cond;
    e.dest   = m_ex.dest;
    e.v1     = m_ex.v1;
    e.v2     = m_ex.v2;
    e.status = m_status;
    e.kill   = CNT_W'(m_kill);
    sb_q.push_back(e);
    @(posedge clk);
    if (m_ex.valid && (!fz || fl)) begin
      if (!cs) m_kill = (m_kill < (1 << CNT_W) - 1) ? m_kill + 1 : m_kill;
      else if (m_ex.s) m_status = af;
    end
    if (fl) m_ex = '0;
    else if (!fz) m_ex = i;
  endtask

  function automatic instr_t mk(input logic v, input logic [3:0] c, input logic s,
                                input logic wb, input logic mw, input logic [3:0] d);
    instr_t r;
    r = '0;
    r.valid = v; r.cond = c; r.s = s; r.wb = wb; r.mw = mw; r.dest = d;
    r.v1 = $urandom; r.v2 = $urandom;
    return r;
  endfunction

  function automatic instr_t rnd();
    instr_t r;
    r = '0;
    r.valid = ($urandom_range(3, 0) != 0);
    r.cond = 4'($urandom); r.s = 1'($urandom); r.wb = 1'($urandom);
    r.mr = 1'($urandom); r.mw = 1'($urandom); r.br = 1'($urandom);
    r.dest = 4'($urandom); r.v1 = $urandom; r.v2 = $urandom;
    return r;
  endfunction

  initial begin
    instr_t a;
    #2;
    chk("rst_ctl", {59'd0, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch}, 64'd0);
    chk("rst_status", {60'd0, status_register}, 64'd0);
    chk("rst_kill", {{(64-CNT_W){1'b0}}, kill_count}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // AL, s=1, wb=1, dest=3, passes with flags 1000
    step(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'd3), 1'b0, 1'b0, 1'b1, 4'b1000);
    // NE fails: annulled, store suppressed, flags kept
    step(mk(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 4'd5), 1'b0, 1'b0, 1'b1, 4'b1000);
    step(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'd7), 1'b0, 1'b0, 1'b0, 4'b0011);
    // freeze three cycles with toggling flags, then release
    a = mk(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd9);
    step(a, 1'b1, 1'b0, 1'b1, 4'b0101);
    step(a, 1'b1, 1'b0, 1'b1, 4'b1010);
    step(a, 1'b1, 1'b0, 1'b1, 4'b0101);
    step(a, 1'b0, 1'b0, 1'b1, 4'b0110);
    // flush together with freeze: EX clears, the instruction in EX retires once
    step(mk(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'd2), 1'b1, 1'b1, 1'b1, 4'b0001);
    step(mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0), 1'b0, 1'b0, 1'b0, 4'b1111);
    // bubbles with failing checker do not count
    step(mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd1), 1'b0, 1'b0, 1'b0, 4'b1111);
    // drive the annul counter past saturation
    for (int k = 0; k < 18; k++)
      step(mk(1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'(k)), 1'b0, 1'b0, 1'b0, 4'b1111);
    step(mk(1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'd4), 1'b0, 1'b0, 1'b0, 4'b1111);
    chk("kill_sat", {{(64-CNT_W){1'b0}}, kill_count}, 64'hF);

    for (int k = 0; k < 400; k++)
      step(rnd(), ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
           1'($urandom), 4'($urandom));

    // set status to 0110 with a valid instruction in EX, then reset between edges
    step(mk(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'd6), 1'b0, 1'b0, 1'b1, 4'b0000);
    step(mk(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 4'd8), 1'b0, 1'b0, 1'b1, 4'b0110);
    step(mk(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 4'd8), 1'b1, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    cond_state = 1'b1; freeze = 1'b1; flush = 1'b1;
    #1;
    chk("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
    chk("pre_rst_status", {60'd0, status_register}, 64'h6);
    rst = 1'b0;
    #1;
    chk("arst_ctl", {59'd0, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch}, 64'd0);
    chk("arst_payload", {ex_val1 | ex_val2, 24'd0, ex_cond, ex_dest}, 64'd0);
    chk("arst_status", {60'd0, status_register}, 64'd0);
    chk("arst_kill", {{(64-CNT_W){1'b0}}, kill_count}, 64'd0);
    @(posedge clk);
    m_ex = '0; m_status = 4'h0; m_kill = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 100; k++)
      step(rnd(), ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
           1'($urandom), 4'($urandom));

    @(negedge clk);
    #4;
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
